// File: rtl/disp_seq_pkg.sv
// Shared screen codes and state encoding for the poker board display sequencer.
// The display multiplexer imports the same package, so both sides decode identical codes.
package disp_seq_pkg;

  // Each state is encoded as its own screen code, so select is a direct copy of the state.
  typedef enum logic [3:0] {
    ST_WALLET = 4'b0001,
    ST_CARDS  = 4'b0010,
    ST_SCORE  = 4'b0011,
    ST_NCARDS = 4'b0100,
    ST_DBL    = 4'b0101,
    ST_HAND   = 4'b0110,
    ST_DRES   = 4'b0111,
    ST_NSCORE = 4'b1011,
    ST_DBLN   = 4'b1101
  } state_t;

  localparam logic [3:0] CODE_BLANK = 4'b0000;

  // The double-up result screen blanks during the odd blink phase.
  function automatic logic [3:0] screen_code(state_t s, logic phase);
    return (s == ST_DRES && phase) ? CODE_BLANK : s;
  endfunction

  function automatic logic is_double(state_t s);
    return (s == ST_DBL) || (s == ST_DBLN) || (s == ST_DRES);
  endfunction

endpackage

// File: rtl/disp_seq_if.sv
// Game-event and screen-output bundle between the game controller and the display sequencer.
interface disp_seq_if;
  logic       tick_en;
  logic       ev_abort;
  logic       ev_deal;
  logic       ev_change;
  logic       ev_judge;
  logic       win;
  logic       ev_double;
  logic       ev_collect;
  logic       ev_dcard;
  logic       ev_guess;
  logic [3:0] select;
  logic       dbl_active;
  logic       seq_done;

  modport master (
    output tick_en, ev_abort, ev_deal, ev_change, ev_judge, win,
           ev_double, ev_collect, ev_dcard, ev_guess,
    input  select, dbl_active, seq_done
  );

  modport slave (
    input  tick_en, ev_abort, ev_deal, ev_change, ev_judge, win,
           ev_double, ev_collect, ev_dcard, ev_guess,
    output select, dbl_active, seq_done
  );
endinterface

// File: rtl/disp_seq_hold_timer.sv
// Saturating tick counter that flags the tick on which it reaches limit-1.
// With AUTO_RESTART it wraps to zero on expire, giving a free-running period.
module hold_timer #(
  parameter int CNT_W        = 8,
  parameter bit AUTO_RESTART = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             tick_en,
  input  logic [CNT_W-1:0] limit,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expire = tick_en && (cnt_q == limit - CNT_W'(1));

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick_en) begin
      if (expire && AUTO_RESTART) cnt_d = '0;
      else if (cnt_q != '1)       cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/disp_seq.sv
// Screen sequencer: steps the display through wallet, cards, hand, score and double-up
// screens on game events and timebase ticks; the double-up result screen blinks.
module disp_seq
  import disp_seq_pkg::*;
#(
  parameter int HOLD_TICKS  = 4,
  parameter int BLINK_TICKS = 2,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  disp_seq_if.slave   bus
);

  state_t     state_q, state_d;
  logic       phase_q, phase_d;
  logic       win_q, win_d;
  logic [3:0] select_q, select_d;
  logic       dbl_q, dbl_d;
  logic       done_q, done_d;
  logic       hold_clr, hold_exp;
  logic       blink_clr, blink_exp;

  // The hold counter restarts on every state change so each screen gets a full hold.
  assign hold_clr  = (state_d != state_q);
  assign blink_clr = (state_q != ST_DRES);

  hold_timer #(.CNT_W(CNT_W), .AUTO_RESTART(1'b0)) u_hold (
    .clk     (clk),
    .rst     (rst),
    .clr     (hold_clr),
    .tick_en (bus.tick_en),
    .limit   (CNT_W'(HOLD_TICKS)),
    .expire  (hold_exp)
  );

  hold_timer #(.CNT_W(CNT_W), .AUTO_RESTART(1'b1)) u_blink (
    .clk     (clk),
    .rst     (rst),
    .clr     (blink_clr),
    .tick_en (bus.tick_en),
    .limit   (CNT_W'(BLINK_TICKS)),
    .expire  (blink_exp)
  );

  always_comb begin
    state_d = state_q;
    if (bus.ev_abort) begin
      state_d = ST_WALLET;
    end else begin
      case (state_q)
        ST_WALLET: if (bus.ev_deal) state_d = ST_CARDS;
        ST_CARDS: begin
          if (bus.ev_change)     state_d = ST_NCARDS;
          else if (bus.ev_judge) state_d = ST_HAND;
        end
        ST_NCARDS: if (hold_exp) state_d = ST_NSCORE;
        ST_NSCORE: if (hold_exp) state_d = ST_HAND;
        ST_HAND:   if (hold_exp) state_d = ST_SCORE;
        ST_SCORE: begin
          // A winning score waits for the player; a losing one times out.
          if (win_q) begin
            if (bus.ev_collect)     state_d = ST_WALLET;
            else if (bus.ev_double) state_d = ST_DBL;
          end else if (hold_exp) begin
            state_d = ST_WALLET;
          end
        end
        ST_DBL:  if (bus.ev_dcard) state_d = ST_DBLN;
        ST_DBLN: if (bus.ev_guess) state_d = ST_DRES;
        ST_DRES: if (hold_exp) state_d = bus.win ? ST_SCORE : ST_WALLET;
        default: state_d = ST_WALLET;
      endcase
    end

    win_d = win_q;
    if ((state_q == ST_HAND || state_q == ST_DRES) && (state_d != state_q))
      win_d = bus.win;

    phase_d  = (state_q == ST_DRES && state_d == ST_DRES) ? (phase_q ^ blink_exp) : 1'b0;
    select_d = screen_code(state_d, phase_d);
    dbl_d    = is_double(state_d);
    done_d   = (state_d == ST_WALLET) && (state_q != ST_WALLET) && !bus.ev_abort;
  end

  // NOTE: the asynchronous reset clears every flop, outputs included, so the display
  // shows the wallet screen the moment rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_WALLET;
      phase_q  <= 1'b0;
      win_q    <= 1'b0;
      select_q <= ST_WALLET;
      dbl_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      win_q    <= win_d;
      select_q <= select_d;
      dbl_q    <= dbl_d;
      done_q   <= done_d;
    end
  end

  assign bus.select     = select_q;
  assign bus.dbl_active = dbl_q;
  assign bus.seq_done   = done_q;

endmodule

// File: tb/tb_disp_seq.sv
// Scoreboard bench for disp_seq: expected screen outputs are queued as each cycle of
// stimulus is driven and compared one cycle later against the registered outputs.
module tb_disp_seq;

  localparam logic [8:0] E_NONE    = 9'h000;
  localparam logic [8:0] E_TICK    = 9'h001;
  localparam logic [8:0] E_GUESS   = 9'h002;
  localparam logic [8:0] E_DCARD   = 9'h004;
  localparam logic [8:0] E_COLLECT = 9'h008;
  localparam logic [8:0] E_DOUBLE  = 9'h010;
  localparam logic [8:0] E_JUDGE   = 9'h020;
  localparam logic [8:0] E_CHANGE  = 9'h040;
  localparam logic [8:0] E_DEAL    = 9'h080;
  localparam logic [8:0] E_ABORT   = 9'h100;

  typedef struct packed {
    logic [3:0] sel;
    logic       dbl;
    logic       done;
  } obs_t;

  typedef struct {
    logic [8:0] ev;
    logic       win;
    obs_t       exp;
  } row_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  obs_t sb[$];

  always #5 clk = ~clk;

  disp_seq_if bus ();

  disp_seq #(.HOLD_TICKS(4), .BLINK_TICKS(2), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic row_t row(logic [8:0] ev, logic win, logic [3:0] sel, logic dbl, logic done);
    row_t r;
    r.ev  = ev;
    r.win = win;
    r.exp = {sel, dbl, done};
    return r;
  endfunction

  // One clock of stimulus: events held across a single rising edge, outputs settle #1 after it.
  task automatic apply(input logic [8:0] ev, input logic w);
    @(negedge clk);
    bus.ev_abort   = ev[8];
    bus.ev_deal    = ev[7];
    bus.ev_change  = ev[6];
    bus.ev_judge   = ev[5];
    bus.ev_double  = ev[4];
    bus.ev_collect = ev[3];
    bus.ev_dcard   = ev[2];
    bus.ev_guess   = ev[1];
    bus.tick_en    = ev[0];
    bus.win        = w;
    @(posedge clk);
    #1;
    {bus.ev_abort, bus.ev_deal, bus.ev_change, bus.ev_judge, bus.ev_double,
     bus.ev_collect, bus.ev_dcard, bus.ev_guess, bus.tick_en} = '0;
  endtask

  task automatic test_reset();
    obs_t got, exp;
    {bus.ev_abort, bus.ev_deal, bus.ev_change, bus.ev_judge, bus.ev_double,
     bus.ev_collect, bus.ev_dcard, bus.ev_guess, bus.tick_en, bus.win} = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    sb.push_back({4'b0001, 1'b0, 1'b0});
    got = {bus.select, bus.dbl_active, bus.seq_done};
    exp = sb.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL reset: got sel=%b dbl=%b done=%b, want sel=%b dbl=%b done=%b",
               got.sel, got.dbl, got.done, exp.sel, exp.dbl, exp.done);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_flow();
    row_t rows[$];
    obs_t got, exp;
    rows = '{row(E_NONE, 0, 4'b0001, 0, 0), row(E_DEAL, 0, 4'b0010, 0, 0),
             row(E_JUDGE, 0, 4'b0110, 0, 0),
             row(E_TICK, 0, 4'b0110, 0, 0), row(E_TICK, 0, 4'b0110, 0, 0),
             row(E_TICK, 0, 4'b0110, 0, 0), row(E_TICK, 0, 4'b0011, 0, 0),
             row(E_TICK, 0, 4'b0011, 0, 0), row(E_TICK, 0, 4'b0011, 0, 0),
             row(E_TICK, 0, 4'b0011, 0, 0), row(E_TICK, 0, 4'b0001, 0, 1),
             row(E_NONE, 0, 4'b0001, 0, 0)};
    foreach (rows[i]) begin
      sb.push_back(rows[i].exp);
      apply(rows[i].ev, rows[i].win);
      got = {bus.select, bus.dbl_active, bus.seq_done};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL basic_flow step %0d: got sel=%b dbl=%b done=%b, want sel=%b dbl=%b done=%b",
                 i, got.sel, got.dbl, got.done, exp.sel, exp.dbl, exp.done);
      end
    end
  endtask

  task automatic test_change_priority();
    row_t rows[$];
    obs_t got, exp;
    rows = '{row(E_DEAL, 0, 4'b0010, 0, 0), row(E_CHANGE | E_JUDGE, 0, 4'b0100, 0, 0),
             row(E_TICK, 0, 4'b0100, 0, 0), row(E_TICK, 0, 4'b0100, 0, 0),
             row(E_TICK, 0, 4'b0100, 0, 0), row(E_TICK, 0, 4'b1011, 0, 0),
             row(E_TICK, 0, 4'b1011, 0, 0), row(E_TICK, 0, 4'b1011, 0, 0),
             row(E_TICK, 0, 4'b1011, 0, 0), row(E_TICK, 1, 4'b0110, 0, 0),
             row(E_TICK, 1, 4'b0110, 0, 0), row(E_TICK, 1, 4'b0110, 0, 0),
             row(E_TICK, 1, 4'b0110, 0, 0), row(E_TICK, 1, 4'b0011, 0, 0)};
    foreach (rows[i]) begin
      sb.push_back(rows[i].exp);
      apply(rows[i].ev, rows[i].win);
      got = {bus.select, bus.dbl_active, bus.seq_done};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL change_priority step %0d: got sel=%b dbl=%b done=%b, want sel=%b dbl=%b done=%b",
                 i, got.sel, got.dbl, got.done, exp.sel, exp.dbl, exp.done);
      end
    end
  endtask

  // Starts in SCORE with a winning hand; ends back in SCORE after a won double-up.
  task automatic test_double_win();
    row_t rows[$];
    obs_t got, exp;
    rows = '{row(E_DOUBLE, 1, 4'b0101, 1, 0), row(E_GUESS, 1, 4'b0101, 1, 0),
             row(E_DCARD, 1, 4'b1101, 1, 0), row(E_GUESS, 1, 4'b0111, 1, 0),
             row(E_NONE, 1, 4'b0111, 1, 0),
             row(E_TICK, 1, 4'b0111, 1, 0), row(E_TICK, 1, 4'b0000, 1, 0),
             row(E_NONE, 1, 4'b0000, 1, 0),
             row(E_TICK, 1, 4'b0000, 1, 0), row(E_TICK, 1, 4'b0011, 0, 0)};
    foreach (rows[i]) begin
      sb.push_back(rows[i].exp);
      apply(rows[i].ev, rows[i].win);
      got = {bus.select, bus.dbl_active, bus.seq_done};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL double_win step %0d: got sel=%b dbl=%b done=%b, want sel=%b dbl=%b done=%b",
                 i, got.sel, got.dbl, got.done, exp.sel, exp.dbl, exp.done);
      end
    end
  endtask

  task automatic test_double_lose();
    row_t rows[$];
    obs_t got, exp;
    rows = '{row(E_DOUBLE, 1, 4'b0101, 1, 0), row(E_DCARD, 1, 4'b1101, 1, 0),
             row(E_GUESS, 0, 4'b0111, 1, 0),
             row(E_TICK, 0, 4'b0111, 1, 0), row(E_TICK, 0, 4'b0000, 1, 0),
             row(E_TICK, 0, 4'b0000, 1, 0), row(E_TICK, 0, 4'b0001, 0, 1),
             row(E_TICK, 0, 4'b0001, 0, 0), row(E_TICK, 0, 4'b0001, 0, 0),
             row(E_TICK, 0, 4'b0001, 0, 0), row(E_TICK, 0, 4'b0001, 0, 0)};
    foreach (rows[i]) begin
      sb.push_back(rows[i].exp);
      apply(rows[i].ev, rows[i].win);
      got = {bus.select, bus.dbl_active, bus.seq_done};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL double_lose step %0d: got sel=%b dbl=%b done=%b, want sel=%b dbl=%b done=%b",
                 i, got.sel, got.dbl, got.done, exp.sel, exp.dbl, exp.done);
      end
    end
  endtask

  task automatic test_abort_and_reset();
    row_t rows[$];
    obs_t got, exp;
    rows = '{row(E_DEAL, 1, 4'b0010, 0, 0), row(E_JUDGE, 1, 4'b0110, 0, 0),
             row(E_TICK, 1, 4'b0110, 0, 0), row(E_TICK, 1, 4'b0110, 0, 0),
             row(E_TICK, 1, 4'b0110, 0, 0), row(E_TICK, 1, 4'b0011, 0, 0),
             row(E_DOUBLE, 1, 4'b0101, 1, 0), row(E_DCARD, 1, 4'b1101, 1, 0),
             row(E_ABORT | E_GUESS, 1, 4'b0001, 0, 0), row(E_NONE, 1, 4'b0001, 0, 0),
             row(E_DEAL, 0, 4'b0010, 0, 0), row(E_CHANGE, 0, 4'b0100, 0, 0),
             row(E_TICK, 0, 4'b0100, 0, 0)};
    foreach (rows[i]) begin
      sb.push_back(rows[i].exp);
      apply(rows[i].ev, rows[i].win);
      got = {bus.select, bus.dbl_active, bus.seq_done};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL abort step %0d: got sel=%b dbl=%b done=%b, want sel=%b dbl=%b done=%b",
                 i, got.sel, got.dbl, got.done, exp.sel, exp.dbl, exp.done);
      end
    end
    // Reset raised between edges: the wallet code must appear before the next rising edge.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    sb.push_back({4'b0001, 1'b0, 1'b0});
    got = {bus.select, bus.dbl_active, bus.seq_done};
    exp = sb.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL async_reset: got sel=%b dbl=%b done=%b, want sel=%b dbl=%b done=%b",
               got.sel, got.dbl, got.done, exp.sel, exp.dbl, exp.done);
    end
    @(negedge clk);
    rst = 1'b0;
    rows = '{row(E_TICK, 0, 4'b0001, 0, 0), row(E_NONE, 0, 4'b0001, 0, 0)};
    foreach (rows[i]) begin
      sb.push_back(rows[i].exp);
      apply(rows[i].ev, rows[i].win);
      got = {bus.select, bus.dbl_active, bus.seq_done};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL post_reset step %0d: got sel=%b dbl=%b done=%b, want sel=%b dbl=%b done=%b",
                 i, got.sel, got.dbl, got.done, exp.sel, exp.dbl, exp.done);
      end
    end
  endtask

  task automatic test_collect_priority();
    row_t rows[$];
    obs_t got, exp;
    rows = '{row(E_DEAL, 1, 4'b0010, 0, 0), row(E_JUDGE, 1, 4'b0110, 0, 0),
             row(E_TICK, 1, 4'b0110, 0, 0), row(E_TICK, 1, 4'b0110, 0, 0),
             row(E_TICK, 1, 4'b0110, 0, 0), row(E_TICK, 1, 4'b0011, 0, 0)};
    for (int i = 0; i < 100; i++) rows.push_back(row(E_TICK, 1, 4'b0011, 0, 0));
    rows.push_back(row(E_DOUBLE | E_COLLECT, 1, 4'b0001, 0, 1));
    rows.push_back(row(E_NONE, 1, 4'b0001, 0, 0));
    foreach (rows[i]) begin
      sb.push_back(rows[i].exp);
      apply(rows[i].ev, rows[i].win);
      got = {bus.select, bus.dbl_active, bus.seq_done};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL collect_priority step %0d: got sel=%b dbl=%b done=%b, want sel=%b dbl=%b done=%b",
                 i, got.sel, got.dbl, got.done, exp.sel, exp.dbl, exp.done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_flow();
    test_change_priority();
    test_double_win();
    test_double_lose();
    test_abort_and_reset();
    test_collect_priority();
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
